// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the GPR write-port arbiter.
// Entry layout uses the default GPR widths.
package wb_port_arbiter_pkg;
   localparam int CH_WB      = 0;
   localparam int CH_TRAP    = 1;
   localparam int GPR_ADDR_W = 5;
   localparam int GPR_DATA_W = 32;

   localparam logic [GPR_ADDR_W-1:0] X0 = '0;

   typedef struct packed {
      logic [GPR_ADDR_W-1:0] addr;
      logic [GPR_DATA_W-1:0] data;
   } wba_ent_t;
endpackage

// File: rtl/wba_entry.sv
// One-entry holding register for a writeback channel.
// Provides the full flag, the load/retire handshake and the operand-hit compare.
module wba_entry
   import wb_port_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_retire,
   input  wba_ent_t              i_ent,
   input  logic [GPR_ADDR_W-1:0] i_rs1,
   input  logic [GPR_ADDR_W-1:0] i_rs2,
   output logic                  o_full,
   output logic                  o_ready,
   output wba_ent_t              o_ent,
   output logic                  o_rs1_hit,
   output logic                  o_rs2_hit
);
   logic     r_full;
   wba_ent_t r_ent;
   logic     w_live;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full <= 1'b0;
         r_ent  <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_ent  <= i_ent;
      end else if (i_retire) begin
         r_full <= 1'b0;
      end
   end

   // A retiring entry can be refilled in the same cycle.
   assign o_ready   = !r_full | i_retire;
   assign o_full    = r_full;
   assign o_ent     = r_ent;
   assign w_live    = r_full & (r_ent.addr != X0);
   assign o_rs1_hit = w_live & (r_ent.addr == i_rs1);
   assign o_rs2_hit = w_live & (r_ent.addr == i_rs2);
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single GPR write port between the commit path and the trap unit.
// Define WBA_BYPASS_EN to add rs1_data/rs2_data bypass outputs.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W  = GPR_DATA_W,
   parameter int ADDR_W  = GPR_ADDR_W,
   parameter bit PRIO_RR = 1'b1
) (
   input  logic [1:0]          in_valid,
   input  logic                clk,
   input  logic                rst,
   output logic [1:0]          in_ready,
   input  logic [2*ADDR_W-1:0] in_addr,
   input  logic [2*DATA_W-1:0] in_data,
   input  logic                wp_ready,
   output logic                wen,
   output logic [ADDR_W-1:0]   waddr,
   output logic [DATA_W-1:0]   wdata,
   output logic [1:0]          done,
   input  logic [ADDR_W-1:0]   rs1_addr,
   input  logic [ADDR_W-1:0]   rs2_addr,
   output logic                rs1_hit,
   output logic                rs2_hit
`ifdef WBA_BYPASS_EN
   ,
   output logic [DATA_W-1:0]   rs1_data,
   output logic [DATA_W-1:0]   rs2_data
`endif
);
   logic [1:0]  w_full;
   logic [1:0]  w_load;
   logic [1:0]  w_done;
   logic [1:0]  w_rs1_hit;
   logic [1:0]  w_rs2_hit;
   wba_ent_t    w_in  [2];
   wba_ent_t    w_ent [2];
   logic        w_gnt;
   logic        w_gnt_vld;
   logic        w_same;
   logic        w_retire;
   logic [ADDR_W-1:0] w_gaddr;

   // r_age names the older channel; r_ptr is the round-robin preference.
   logic r_age;
   logic r_ptr;
   logic r_hold;
   logic r_hold_ch;

   assign w_load = in_valid & in_ready;

   for (genvar k = 0; k < 2; k++) begin : g_ch
      assign w_in[k].addr = in_addr[k*ADDR_W +: ADDR_W];
      assign w_in[k].data = in_data[k*DATA_W +: DATA_W];

      wba_entry u_ent (
         .clk       (clk),
         .rst       (rst),
         .i_load    (w_load[k]),
         .i_retire  (w_done[k]),
         .i_ent     (w_in[k]),
         .i_rs1     (rs1_addr),
         .i_rs2     (rs2_addr),
         .o_full    (w_full[k]),
         .o_ready   (in_ready[k]),
         .o_ent     (w_ent[k]),
         .o_rs1_hit (w_rs1_hit[k]),
         .o_rs2_hit (w_rs2_hit[k])
      );
   end

   assign w_same = (w_ent[CH_WB].addr == w_ent[CH_TRAP].addr)
                 & (w_ent[CH_WB].addr != X0);

   // A stalled grant is pinned so the write port never switches mid-stall.
   always_comb begin
      w_gnt     = 1'b0;
      w_gnt_vld = |w_full;
      if (r_hold) begin
         w_gnt = r_hold_ch;
      end else if (&w_full) begin
         if (w_same)
            w_gnt = r_age;
         else
            w_gnt = PRIO_RR ? r_ptr : 1'b1;
      end else begin
         w_gnt = w_full[CH_TRAP];
      end
   end

   assign w_gaddr  = w_ent[w_gnt].addr;
   assign w_retire = w_gnt_vld & ((w_gaddr == X0) | wp_ready);
   assign w_done   = {w_retire & w_gnt, w_retire & ~w_gnt};

   assign wen   = w_gnt_vld & (w_gaddr != X0);
   assign waddr = w_gnt_vld ? w_gaddr : '0;
   assign wdata = w_gnt_vld ? w_ent[w_gnt].data : '0;
   assign done  = w_done;

   assign rs1_hit = |w_rs1_hit;
   assign rs2_hit = |w_rs2_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_age     <= 1'b0;
         r_ptr     <= 1'b0;
         r_hold    <= 1'b0;
         r_hold_ch <= 1'b0;
      end else begin
         r_hold    <= w_gnt_vld & !w_retire;
         r_hold_ch <= w_gnt;
         if ((&w_full) & w_retire)
            r_ptr <= !w_gnt;
         if (&w_load)
            r_age <= 1'b0;
         else if (w_load[CH_WB])
            r_age <= 1'b1;
         else if (w_load[CH_TRAP])
            r_age <= 1'b0;
      end
   end

`ifdef WBA_BYPASS_EN
   // Both entries matching implies both full, so r_age is meaningful.
   assign rs1_data = (&w_rs1_hit) ? w_ent[!r_age].data :
                     w_rs1_hit[1] ? w_ent[1].data :
                     w_rs1_hit[0] ? w_ent[0].data : '0;
   assign rs2_data = (&w_rs2_hit) ? w_ent[!r_age].data :
                     w_rs2_hit[1] ? w_ent[1].data :
                     w_rs2_hit[0] ? w_ent[0].data : '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: round-robin (dut 0) and fixed-priority (dut 1)
// instances, with a per-channel scoreboard of expected writes.
module tb_wb_port_arbiter;
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] dt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  vld  [2];
   logic [9:0]  addr [2];
   logic [63:0] data [2];
   logic        wpr  [2];
   logic [4:0]  rs1  [2];
   logic [4:0]  rs2  [2];
   logic [1:0]  rdy  [2];
   logic [1:0]  done [2];
   logic        wen  [2];
   logic [4:0]  wa   [2];
   logic [31:0] wd   [2];
   logic        h1   [2];
   logic        h2   [2];
`ifdef WBA_BYPASS_EN
   logic [31:0] bd1  [2];
   logic [31:0] bd2  [2];
`endif

   exp_t sb [4][$];
   int checks;
   int errors;

   wb_port_arbiter #(.PRIO_RR(1'b1)) u_rr (
      .clk(clk), .rst(rst),
      .in_valid(vld[0]), .in_ready(rdy[0]),
      .in_addr(addr[0]), .in_data(data[0]),
      .wp_ready(wpr[0]), .wen(wen[0]),
      .waddr(wa[0]), .wdata(wd[0]), .done(done[0]),
      .rs1_addr(rs1[0]), .rs2_addr(rs2[0]),
      .rs1_hit(h1[0]), .rs2_hit(h2[0])
`ifdef WBA_BYPASS_EN
      , .rs1_data(bd1[0]), .rs2_data(bd2[0])
`endif
   );

   wb_port_arbiter #(.PRIO_RR(1'b0)) u_fp (
      .clk(clk), .rst(rst),
      .in_valid(vld[1]), .in_ready(rdy[1]),
      .in_addr(addr[1]), .in_data(data[1]),
      .wp_ready(wpr[1]), .wen(wen[1]),
      .waddr(wa[1]), .wdata(wd[1]), .done(done[1]),
      .rs1_addr(rs1[1]), .rs2_addr(rs2[1]),
      .rs1_hit(h1[1]), .rs2_hit(h2[1])
`ifdef WBA_BYPASS_EN
      , .rs1_data(bd1[1]), .rs2_data(bd2[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Retires pop the scoreboard before accepted loads push, so a
   // same-cycle drain and refill keep their order.
   task automatic step();
      exp_t e;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (wen[d] && wpr[d]) begin
            checks++;
            if (done[d] == 2'b00) begin
               errors++;
               $display("FAIL wr_retire dut%0d: done=%b want nonzero", d, done[d]);
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (done[d][k]) begin
               checks++;
               if (sb[d*2+k].size() == 0) begin
                  errors++;
                  $display("FAIL sb_empty dut%0d ch%0d: done with nothing expected", d, k);
               end else begin
                  e = sb[d*2+k].pop_front();
                  if (wen[d] !== (e.a != 5'd0) || wa[d] !== e.a || wd[d] !== e.dt) begin
                     errors++;
                     $display("FAIL sb_data dut%0d ch%0d: got wen=%b a=%0d d=%h want wen=%b a=%0d d=%h",
                              d, k, wen[d], wa[d], wd[d], (e.a != 5'd0), e.a, e.dt);
                  end
               end
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (vld[d][k] && rdy[d][k]) begin
               e.a  = addr[d][k*5 +: 5];
               e.dt = data[d][k*32 +: 32];
               sb[d*2+k].push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({wen[d], wa[d], wd[d], done[d], h1[d], h2[d]} !== '0) begin
            errors++;
            $display("FAIL reset_out dut%0d: wen=%b a=%0d d=%h done=%b h=%b%b want all 0",
                     d, wen[d], wa[d], wd[d], done[d], h1[d], h2[d]);
         end
      end
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdy[d] !== 2'b11) begin
            errors++;
            $display("FAIL reset_rdy dut%0d: got %b want 11", d, rdy[d]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      wpr[0]  = 1'b1;
      rs1[0]  = 5'd5;
      vld[0]  = 2'b01;
      addr[0] = {5'd0, 5'd5};
      data[0] = {32'h0, 32'h0000_1234};
      step();
      vld[0] = 2'b00;
      #1;
      checks++;
      if (wen[0] !== 1'b1 || wa[0] !== 5'd5 || wd[0] !== 32'h1234 ||
          done[0] !== 2'b01 || h1[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_wr: wen=%b a=%0d d=%h done=%b hit=%b want 1 5 1234 01 1",
                  wen[0], wa[0], wd[0], done[0], h1[0]);
      end
      step();
      checks++;
      if (wen[0] !== 1'b0 || h1[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: wen=%b hit=%b want 0 0", wen[0], h1[0]);
      end
      rs1[0] = 5'd0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_d;
      wpr[0]  = 1'b1;
      vld[0]  = 2'b11;
      addr[0] = {5'd7, 5'd3};
      for (int i = 0; i < 8; i++) begin
         data[0] = {32'h200 + 32'(i), 32'h100 + 32'(i)};
         #1;
         exp_d = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10);
         checks++;
         if (done[0] !== exp_d || rdy[0] !== ((i == 0) ? 2'b11 : exp_d)) begin
            errors++;
            $display("FAIL rr_cycle%0d: done=%b rdy=%b want done=%b", i, done[0], rdy[0], exp_d);
         end
         step();
      end
      vld[0] = 2'b00;
      repeat (3) step();
   endtask

   task automatic test_same_addr();
      wpr[1]  = 1'b0;
      rs1[1]  = 5'd9;
      vld[1]  = 2'b01;
      addr[1] = {5'd0, 5'd9};
      data[1] = {32'h0, 32'hAAAA_0001};
      step();
      vld[1]  = 2'b10;
      addr[1] = {5'd9, 5'd0};
      data[1] = {32'hBBBB_0002, 32'h0};
      #1;
      checks++;
      if (h1[1] !== 1'b1 || wen[1] !== 1'b1 || wa[1] !== 5'd9 || wd[1] !== 32'hAAAA_0001) begin
         errors++;
         $display("FAIL same_first: hit=%b wen=%b a=%0d d=%h want 1 1 9 aaaa0001",
                  h1[1], wen[1], wa[1], wd[1]);
      end
      step();
      vld[1] = 2'b00;
      #1;
      checks++;
      if (h1[1] !== 1'b1 || wd[1] !== 32'hAAAA_0001 || done[1] !== 2'b00) begin
         errors++;
         $display("FAIL same_hold: hit=%b d=%h done=%b want 1 aaaa0001 00", h1[1], wd[1], done[1]);
      end
`ifdef WBA_BYPASS_EN
      checks++;
      if (bd1[1] !== 32'hBBBB_0002) begin
         errors++;
         $display("FAIL same_bypass: got %h want bbbb0002", bd1[1]);
      end
`endif
      step();
      wpr[1] = 1'b1;
      #1;
      checks++;
      if (done[1] !== 2'b01) begin
         errors++;
         $display("FAIL same_order0: done=%b want 01", done[1]);
      end
      step();
      checks++;
      if (done[1] !== 2'b10 || wd[1] !== 32'hBBBB_0002 || h1[1] !== 1'b1) begin
         errors++;
         $display("FAIL same_order1: done=%b d=%h hit=%b want 10 bbbb0002 1", done[1], wd[1], h1[1]);
      end
      step();
      checks++;
      if (h1[1] !== 1'b0 || wen[1] !== 1'b0) begin
         errors++;
         $display("FAIL same_clear: hit=%b wen=%b want 0 0", h1[1], wen[1]);
      end
      rs1[1] = 5'd0;
   endtask

   task automatic test_fixed_prio();
      wpr[1]  = 1'b1;
      vld[1]  = 2'b11;
      addr[1] = {5'd7, 5'd3};
      data[1] = {32'hC000_0002, 32'hC000_0001};
      step();
      vld[1] = 2'b00;
      #1;
      checks++;
      if (done[1] !== 2'b10) begin
         errors++;
         $display("FAIL fp_ch1_first: done=%b want 10", done[1]);
      end
      step();
      checks++;
      if (done[1] !== 2'b01) begin
         errors++;
         $display("FAIL fp_ch0_next: done=%b want 01", done[1]);
      end
      step();
      rs2[1]  = 5'd12;
      vld[1]  = 2'b11;
      addr[1] = {5'd12, 5'd12};
      data[1] = {32'hD000_0002, 32'hD000_0001};
      step();
      vld[1] = 2'b00;
      #1;
      checks++;
      if (done[1] !== 2'b01 || wd[1] !== 32'hD000_0001 || h2[1] !== 1'b1) begin
         errors++;
         $display("FAIL fp_age: done=%b d=%h hit=%b want 01 d0000001 1", done[1], wd[1], h2[1]);
      end
`ifdef WBA_BYPASS_EN
      checks++;
      if (bd2[1] !== 32'hD000_0002) begin
         errors++;
         $display("FAIL fp_bypass: got %h want d0000002", bd2[1]);
      end
`endif
      step();
      checks++;
      if (done[1] !== 2'b10) begin
         errors++;
         $display("FAIL fp_age_next: done=%b want 10", done[1]);
      end
      step();
      rs2[1] = 5'd0;
   endtask

   task automatic test_x0();
      wpr[0]  = 1'b0;
      rs1[0]  = 5'd0;
      vld[0]  = 2'b01;
      addr[0] = {5'd0, 5'd0};
      data[0] = {32'h0, 32'h0000_FFFF};
      step();
      vld[0] = 2'b00;
      #1;
      checks++;
      if (wen[0] !== 1'b0 || done[0] !== 2'b01 || h1[0] !== 1'b0) begin
         errors++;
         $display("FAIL x0_drain: wen=%b done=%b hit=%b want 0 01 0", wen[0], done[0], h1[0]);
      end
      step();
      checks++;
      if (done[0] !== 2'b00 || h1[0] !== 1'b0) begin
         errors++;
         $display("FAIL x0_after: done=%b hit=%b want 00 0", done[0], h1[0]);
      end
   endtask

   task automatic test_stall();
      wpr[0]  = 1'b0;
      vld[0]  = 2'b01;
      addr[0] = {5'd0, 5'd6};
      data[0] = {32'h0, 32'h0000_ABCD};
      step();
      vld[0] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (wen[0] !== 1'b1 || wa[0] !== 5'd6 || wd[0] !== 32'hABCD ||
             done[0] !== 2'b00 || rdy[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d: wen=%b a=%0d d=%h done=%b rdy=%b want 1 6 abcd 00 x0",
                     i, wen[0], wa[0], wd[0], done[0], rdy[0]);
         end
         step();
      end
      wpr[0]  = 1'b1;
      vld[0]  = 2'b01;
      addr[0] = {5'd0, 5'd8};
      data[0] = {32'h0, 32'h0000_5555};
      #1;
      checks++;
      if (done[0] !== 2'b01 || rdy[0][0] !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: done=%b rdy=%b want 01 x1", done[0], rdy[0]);
      end
      step();
      vld[0] = 2'b00;
      #1;
      checks++;
      if (wa[0] !== 5'd8 || wd[0] !== 32'h5555 || done[0] !== 2'b01) begin
         errors++;
         $display("FAIL stall_refill: a=%0d d=%h done=%b want 8 5555 01", wa[0], wd[0], done[0]);
      end
      step();
      checks++;
      if (wen[0] !== 1'b0) begin
         errors++;
         $display("FAIL stall_idle: wen=%b want 0", wen[0]);
      end
   endtask

   task automatic test_reset_mid();
      wpr[0]  = 1'b0;
      rs1[0]  = 5'd4;
      rs2[0]  = 5'd10;
      vld[0]  = 2'b11;
      addr[0] = {5'd10, 5'd4};
      data[0] = {32'hE000_0002, 32'hE000_0001};
      step();
      vld[0] = 2'b00;
      #1;
      checks++;
      if (h1[0] !== 1'b1 || h2[0] !== 1'b1 || wen[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_full: h1=%b h2=%b wen=%b want 1 1 1", h1[0], h2[0], wen[0]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (wen[0] !== 1'b0 || h1[0] !== 1'b0 || h2[0] !== 1'b0 || done[0] !== 2'b00) begin
         errors++;
         $display("FAIL mid_async: wen=%b h1=%b h2=%b done=%b want 0 0 0 00",
                  wen[0], h1[0], h2[0], done[0]);
      end
      sb[0].delete();
      sb[1].delete();
      step();
      rst    = 1'b1;
      wpr[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (wen[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale%0d: wen=%b want 0", i, wen[0]);
         end
         step();
      end
      rs1[0] = 5'd0;
      rs2[0] = 5'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         vld[d]  = 2'b00;
         addr[d] = '0;
         data[d] = '0;
         wpr[d]  = 1'b0;
         rs1[d]  = '0;
         rs2[d]  = '0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_same_addr();
      test_fixed_prio();
      test_x0();
      test_stall();
      test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sb[i].size() != 0) begin
            errors++;
            $display("FAIL sb_left q%0d: %0d entries never written, want 0", i, sb[i].size());
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single GPR write port between two writeback requesters.
  - ch0: the LSU/WBU commit path, which selects and sign-/zero-extends ALU, load or CSR data.
  - ch1: the trap/CSR unit.
- Each channel has a one-entry holding register with a valid/ready handshake.
- Arbitration is round-robin or fixed-priority, and a same-address write-ordering rule always applies.
- Exposes a pending-write scoreboard to the IDU so operand reads can stall or bypass. Sits between the writeback stage and the register file.

Parameters:
- DATA_W, 32, GPR data width.
- ADDR_W, 5, GPR index width.
- PRIO_RR, 1, 1 = round-robin between channels; 0 = fixed priority, ch1 wins.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  2  per-channel request valid; bit k = channel k.
- in_ready  output  2  per-channel accept.
- in_addr  input  2*ADDR_W  destination index; [ADDR_W-1:0] = ch0.
- in_data  input  2*DATA_W  write data; [DATA_W-1:0] = ch0.
- wp_ready  input  1  register file can take a write this cycle.
- wen  output  1  GPR write enable.
- waddr  output  ADDR_W  GPR write index.
- wdata  output  DATA_W  GPR write data.
- done  output  2  one-cycle pulse: channel k's entry retired.
- rs1_addr, rs2_addr  input  ADDR_W each  IDU operand indices.
- rs1_hit, rs2_hit  output  1 each  a held entry targets that operand.

Behaviour:
- Reset (rst low, asynchronous):
  - full[1:0]=0, age bit=0, RR pointer=ch0 preferred.
  - Outputs: wen=0, waddr=0, wdata=0, done=0, hits=0, in_ready=2'b11 once rst is released.
  - A reset mid-operation discards held entries; no writes are issued.
- Load: entry k loads in_addr/in_data when in_valid[k]&in_ready[k].
  - in_ready[k] = !full[k] | retire[k], so drain and refill can happen in the same cycle; full throughput is 1 write/cycle per channel.
- Latency: a request accepted in cycle N can write in N+1 at the earliest. Outputs are combinational from held entries, not from in_*.
- Grant: selects one full entry per cycle.
  - If both entries are full with equal non-zero addr, the older one (age bit) is granted, regardless of PRIO_RR.
  - Else with PRIO_RR=1: the preferred channel wins; the pointer flips to the other channel after each retire of a contested grant (both full).
  - Else with PRIO_RR=0: ch1 wins.
  - A single full entry is always granted.
- Age: a load sets age to "younger" for the loaded channel. On a simultaneous load of both channels, ch1 is younger.
- Write:
  - wen = granted & (addr!=0); waddr/wdata come from the granted entry, and are 0 when there is no grant.
  - Retire happens when (wen & wp_ready) or (granted & addr==0).
  - x0 entries drain without wen and without needing wp_ready.
- done[k] pulses in the retire cycle.
- Without wp_ready, the granted entry holds and its outputs stay stable; the grant does not change until retire, so there is no switching mid-stall.
- Hits: rsX_hit = OR over full entries with addr==rsX_addr and addr!=0. In-flight in_* requests are not checked. An entry retiring this cycle still reports a hit.

Optional Feature:
- Macro WBA_BYPASS_EN.
- Defined: adds outputs rs1_data and rs2_data (DATA_W each), driven by the data of the youngest matching full entry, or 0 on no hit. The IDU bypasses instead of stalling.
- Undefined: the ports are absent; only the hit flags exist and the IDU stalls on a hit.

Decomposition:
- Shared package holds:
  - channel index constants CH_WB=0, CH_TRAP=1;
  - the entry struct type {addr, data};
  - X0 = 0.
- One natural sub-module, wba_entry: a single holding register with full flag, load/retire handshake and address compare. Instantiate it twice.

Test Plan:
- ch0 loads addr=5, data=0x1234 in cycle 1 with wp_ready=1 -> cycle 2 wen=1, waddr=5, wdata=0x1234, done=2'b01; cycle 3 wen=0.
- Both channels valid every cycle with PRIO_RR=1 and distinct addrs 3/7 -> retires alternate ch0, ch1, ch0, ...; in_ready deasserts on the losing channel while its entry is full.
- ch0 loads addr=9 in cycle 1, ch1 loads addr=9 in cycle 2, PRIO_RR=0 -> ch0 is written first despite fixed priority, ch1 next; rs1_addr=9 hits throughout, and with WBA_BYPASS_EN rs1_data returns ch1's data once loaded.
- ch0 loads addr=0, data=0xFFFF with wp_ready=0 -> no wen, done[0] pulses next cycle, rs1_addr=0 never hits.
- Held entry with wp_ready=0 for 4 cycles -> waddr/wdata stable and wen=1 throughout; retires on the first cycle wp_ready=1, with same-cycle refill accepted.
- rst driven low while both entries are full -> wen=0 and hits=0 immediately, asynchronously; after release, no stale write is issued.
